custom_sync_fifo: RTL and testbench



---
 rtl/custom_sync_fifo.sv | 89 ++++++++
 tb/tb_custom_sync_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/custom_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 2^ADDRSIZE x DATADDRSIZE, async active-low reset.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module custom_sync_fifo #(
    parameter int DATADDRSIZE = 8,
    parameter int ADDRSIZE    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [DATADDRSIZE-1:0] din,
    input  logic                   wen,
    input  logic                   ren,
    output logic [DATADDRSIZE-1:0] dout,
    output logic                   fifo_full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                   fifo_empty,
    output logic                   wr_overflow_o,
    output logic                   rd_underflow_o
`else
    output logic                   fifo_empty
`endif
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [ADDRSIZE:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE:0]      rd_ptr_q, rd_ptr_d;
    logic [DATADDRSIZE-1:0] mem_q [DEPTH];
    logic                   wr_acc, rd_acc;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDRSIZE] != rd_ptr_q[ADDRSIZE]) &&
                        (wr_ptr_q[ADDRSIZE-1:0] == rd_ptr_q[ADDRSIZE-1:0]);

    assign wr_acc = wen && !fifo_full;
    assign rd_acc = ren && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so dout reads zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_ptr_q[ADDRSIZE-1:0]] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[ADDRSIZE-1:0]];

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wen & fifo_full);
        udf_d = udf_q | (ren & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign wr_overflow_o  = ovf_q;
    assign rd_underflow_o = udf_q;
`endif

endmodule

// File: tb/tb_custom_sync_fifo.sv
// Self-checking bench for custom_sync_fifo: queue model checked every cycle plus directed literals.
module tb_custom_sync_fifo;
    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic [7:0] din = '0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] dout;
    logic       fifo_full, fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       wr_overflow_o, rd_underflow_o;
`endif

    custom_sync_fifo #(.DATADDRSIZE(8), .ADDRSIZE(4)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .din        (din),
        .wen        (wen),
        .ren        (ren),
        .dout       (dout),
        .fifo_full  (fifo_full),
`ifdef FIFO_ERR_FLAGS_EN
        .fifo_empty    (fifo_empty),
        .wr_overflow_o (wr_overflow_o),
        .rd_underflow_o(rd_underflow_o)
`else
        .fifo_empty (fifo_empty)
`endif
    );

    always #5 clk_i = ~clk_i;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic       chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model takes the accept decision from its own occupancy.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic wa, ra;
        wen = w; ren = r; din = d;
        @(posedge clk_i);
        wa = w && (q.size() < DEPTH);
        ra = r && (q.size() > 0);
        if (w && q.size() == DEPTH) m_ovf = 1'b1;
        if (r && q.size() == 0)     m_udf = 1'b1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(d);
        #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (chk_en && rst_n_i) begin
            check("empty", fifo_empty, q.size() == 0);
            check("full",  fifo_full,  q.size() == DEPTH);
            if (q.size() > 0) check("dout", dout, q[0]);
`ifdef FIFO_ERR_FLAGS_EN
            check("ovf", wr_overflow_o, m_ovf);
            check("udf", rd_underflow_o, m_udf);
`endif
        end
    end

    initial begin
        // Reset: outputs must be valid before any clock edge.
        #1 rst_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_empty", fifo_empty, 1);
        check("rst_full",  fifo_full,  0);
        check("rst_dout",  dout,       8'h00);
        repeat (5) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        check("rel_empty", fifo_empty, 1);
        check("rel_dout",  dout,       8'h00);
        chk_en = 1'b1;

        // Single word, plus a pop on empty that must be ignored.
        step(0, 1, 8'h00);
        check("pop_empty", fifo_empty, 1);
        step(1, 0, 8'hA5);
        check("single_empty", fifo_empty, 0);
        check("single_dout",  dout,       8'hA5);
        step(0, 1, 8'h00);
        check("single_pop", fifo_empty, 1);

        // Fill to full, drop a 17th write, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
        check("fill_full", fifo_full, 1);
        check("fill_head", dout, 8'h00);
        step(1, 0, 8'hFF);
        check("ovf_full", fifo_full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_dout", dout, 8'(i));
            step(0, 1, 8'h00);
        end
        check("drain_empty", fifo_empty, 1);

        // Three stored, then ten cycles of simultaneous push/pop.
        step(1, 0, 8'h10);
        step(1, 0, 8'h11);
        step(1, 0, 8'h12);
        for (int i = 0; i < 10; i++) begin
            check("sim_dout", dout, (i < 3) ? 8'(8'h10 + i) : 8'(8'h20 + i - 3));
            check("sim_empty", fifo_empty, 0);
            check("sim_full",  fifo_full,  0);
            step(1, 1, 8'(8'h20 + i));
        end
        for (int i = 0; i < 3; i++) begin
            check("sim_tail", dout, 8'(8'h27 + i));
            step(0, 1, 8'h00);
        end
        check("sim_end_empty", fifo_empty, 1);

        // Alternating traffic on even cycles with random gating, twice.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 460; i++) begin
                logic w, r;
                w = (i % 2 == 0) && ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
                r = (i % 2 == 0) && ($urandom_range(0, 2) == 0) && (q.size() > 0);
                step(w, r, 8'($urandom));
            end
            while (q.size() > 0) step(0, 1, 8'h00);
        end

        // Seven words stored, then asynchronous reset between edges.
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h50 + i));
        check("pre_rst_dout", dout, 8'h50);
        #2 rst_n_i = 1'b0;
        model_reset();
        #1;
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_full",  fifo_full,  0);
        check("mid_rst_dout",  dout,       8'h00);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        step(0, 1, 8'h00);
        check("post_rst_empty", fifo_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("udf_set", rd_underflow_o, 1);
        check("ovf_clr", wr_overflow_o,  0);
        repeat (3) step(0, 0, 8'h00);
        check("udf_sticky", rd_underflow_o, 1);
`else
        repeat (3) step(0, 0, 8'h00);
`endif
        step(1, 0, 8'h77);
        check("post_rst_dout", dout, 8'h77);
        step(0, 1, 8'h00);
        @(negedge clk_i);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
